// File: rtl/if_fetch_if.sv
`timescale 1ns/1ps
// Instruction-memory handshake bundle: request/grant on the way out,
// in-order valid/data responses on the way back.
interface if_fetch_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/if_fetch.sv
`timescale 1ns/1ps
// Instruction-fetch stage: owns the PC, issues credit-limited requests to
// instruction memory and queues returned words (with PC, PC+4) for IF_ID.
module if_fetch #(
  parameter int               ADDR_W   = 32,
  parameter int               INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  if_fetch_if.master         imem,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [ADDR_W-1:0]  pc_plus4_out
);
  logic [ADDR_W-1:0]  fetch_pc_reg;
  logic [1:0]         outstanding_reg;
  logic [1:0]         discard_reg;
  logic [1:0]         q_count_reg;
  logic               pcf_wr_reg, pcf_rd_reg;
  logic               q_wr_reg, q_rd_reg;
  logic [ADDR_W-1:0]  pcf_mem     [2];
  logic [ADDR_W-1:0]  q_pc_mem    [2];
  logic [ADDR_W-1:0]  q_pc4_mem   [2];
  logic [INSTR_W-1:0] q_instr_mem [2];

  logic [2:0]         credits_used;
  logic               accept, resp, push, pop;
  logic [ADDR_W-1:0]  redirect_target;
  logic [ADDR_W-1:0]  resp_pc;

  // Discarded responses still hold credits until they come back.
  assign credits_used    = {1'b0, outstanding_reg} + {1'b0, q_count_reg};
  assign imem.imem_req   = rst_n & ~redirect & (credits_used < 3'd2);
  assign imem.imem_addr  = fetch_pc_reg;
  assign accept          = imem.imem_req & imem.imem_gnt;
  assign resp            = imem.imem_rvalid;
  assign push            = resp & (discard_reg == 2'd0) & ~redirect;
  assign pop             = instr_valid & ~stall & ~redirect;
  assign redirect_target = redirect_pc & ~ADDR_W'(3);
  assign resp_pc         = pcf_mem[pcf_rd_reg];

  assign instr_valid  = (q_count_reg != 2'd0);
  assign instr_out    = q_instr_mem[q_rd_reg];
  assign pc_out       = q_pc_mem[q_rd_reg];
  assign pc_plus4_out = q_pc4_mem[q_rd_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_reg    <= RESET_PC;
      outstanding_reg <= 2'd0;
      discard_reg     <= 2'd0;
      q_count_reg     <= 2'd0;
      pcf_wr_reg      <= 1'b0;
      pcf_rd_reg      <= 1'b0;
      q_wr_reg        <= 1'b0;
      q_rd_reg        <= 1'b0;
    end else begin
      if (redirect)
        fetch_pc_reg <= redirect_target;
      else if (accept)
        fetch_pc_reg <= fetch_pc_reg + ADDR_W'(4);

      outstanding_reg <= outstanding_reg + {1'b0, accept} - {1'b0, resp};
      if (accept) pcf_wr_reg <= ~pcf_wr_reg;
      if (resp)   pcf_rd_reg <= ~pcf_rd_reg;

      // Everything still in flight, minus a response landing now, is stale.
      if (redirect)
        discard_reg <= outstanding_reg - {1'b0, resp};
      else if (resp && discard_reg != 2'd0)
        discard_reg <= discard_reg - 2'd1;

      if (redirect) begin
        q_count_reg <= 2'd0;
        q_wr_reg    <= 1'b0;
        q_rd_reg    <= 1'b0;
      end else begin
        if (push) q_wr_reg <= ~q_wr_reg;
        if (pop)  q_rd_reg <= ~q_rd_reg;
        q_count_reg <= q_count_reg + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        pcf_mem[i]     <= '0;
        q_pc_mem[i]    <= '0;
        q_pc4_mem[i]   <= '0;
        q_instr_mem[i] <= '0;
      end
    end else begin
      if (accept)
        pcf_mem[pcf_wr_reg] <= fetch_pc_reg;
      if (push) begin
        q_pc_mem[q_wr_reg]    <= resp_pc;
        q_pc4_mem[q_wr_reg]   <= resp_pc + ADDR_W'(4);
        q_instr_mem[q_wr_reg] <= imem.imem_rdata;
      end
    end
  end

  a_no_queue_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && q_count_reg == 2'd2));
  a_no_credit_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(accept && !resp && outstanding_reg == 2'd2));
endmodule

// File: tb/tb_if_fetch.sv
`timescale 1ns/1ps
// Bench for if_fetch: behavioural instruction memory, a scoreboard of granted
// fetches checked at consumption, and one task per scenario.
module tb_if_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr_out, pc_out, pc4;

  logic        w_stall = 1'b0;
  logic        w_redirect = 1'b0;
  logic [31:0] w_redirect_pc = '0;
  logic        w_valid;
  logic [31:0] w_instr, w_pc, w_pc4;

  if_fetch_if #(.ADDR_W(32), .INSTR_W(32)) mif ();
  if_fetch_if #(.ADDR_W(32), .INSTR_W(32)) wif ();

  if_fetch #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem(mif), .instr_valid(instr_valid), .instr_out(instr_out), .pc_out(pc_out),
    .pc_plus4_out(pc4));

  if_fetch #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .stall(w_stall), .redirect(w_redirect), .redirect_pc(w_redirect_pc),
    .imem(wif), .instr_valid(w_valid), .instr_out(w_instr), .pc_out(w_pc),
    .pc_plus4_out(w_pc4));

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; int due;} pend_t;
  pend_t       pend[$];
  logic [63:0] sb[$];
  logic [31:0] acc_log[$];
  logic [31:0] w_seen[$];
  int          cyc = 0;
  int          lat = 1;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5EED;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Main memory model + scoreboard: a grant pushes the expected entry,
  // a consumption pops and compares it, a redirect drops everything pending.
  initial begin
    logic [63:0] exp_e;
    mif.imem_gnt = 1'b0; mif.imem_rvalid = 1'b0; mif.imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n && pend.size() > 0 && pend[0].due <= cyc) begin
        mif.imem_rvalid = 1'b1;
        mif.imem_rdata  = mem_data(pend[0].addr);
      end else begin
        mif.imem_rvalid = 1'b0;
        mif.imem_rdata  = '0;
      end
      #3;
      if (!rst_n) begin
        pend.delete(); sb.delete(); mif.imem_rvalid = 1'b0;
      end else begin
        if (mif.imem_rvalid) void'(pend.pop_front());
        if (mif.imem_req && mif.imem_gnt) begin
          pend.push_back('{mif.imem_addr, cyc + lat});
          acc_log.push_back(mif.imem_addr);
          sb.push_back({mif.imem_addr, mem_data(mif.imem_addr)});
        end
        if (redirect) sb.delete();
        else if (instr_valid && !stall) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL sb_unexpected: got pc=%h instr=%h, required no output", pc_out, instr_out);
          end else begin
            exp_e = sb.pop_front();
            $display("consume pc=%h instr=%h pc4=%h", pc_out, instr_out, pc4);
            if ({pc_out, instr_out} !== exp_e || pc4 !== exp_e[63:32] + 32'd4) begin
              n_bad++;
              $display("FAIL sb_entry: got pc=%h instr=%h pc4=%h, required pc=%h instr=%h pc4=%h",
                       pc_out, instr_out, pc4, exp_e[63:32], exp_e[31:0], exp_e[63:32] + 32'd4);
            end
          end
        end
      end
    end
  end

  // Wrap instance memory: fixed one-cycle response latency, always granting.
  initial begin
    logic        pv;
    logic [31:0] pa;
    pv = 1'b0; pa = '0;
    wif.imem_gnt = 1'b1; wif.imem_rvalid = 1'b0; wif.imem_rdata = '0;
    forever begin
      @(negedge clk);
      wif.imem_rvalid = pv;
      wif.imem_rdata  = mem_data(pa);
      #3;
      if (!rst_n) begin
        pv = 1'b0; wif.imem_rvalid = 1'b0; w_seen.delete();
      end else begin
        pv = wif.imem_req && wif.imem_gnt;
        pa = wif.imem_addr;
        if (pv) w_seen.push_back(wif.imem_addr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic do_reset(input int l, input logic s);
    @(negedge clk);
    rst_n = 1'b0; lat = l; stall = s; redirect = 1'b0; mif.imem_gnt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    acc_log.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    n_cmp++; if (mif.imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b required 0", mif.imem_req); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b required 0", instr_valid); end
    n_cmp++; if (instr_out !== 32'h0) begin n_bad++; $display("FAIL rst_instr: got %h required 0", instr_out); end
    n_cmp++; if (pc_out !== 32'h0) begin n_bad++; $display("FAIL rst_pc: got %h required 0", pc_out); end
    n_cmp++; if (pc4 !== 32'h0) begin n_bad++; $display("FAIL rst_pc4: got %h required 0", pc4); end
    n_cmp++; if (mif.imem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr: got %h required 0", mif.imem_addr); end
    n_cmp++; if (wif.imem_addr !== 32'hFFFF_FFF8) begin n_bad++; $display("FAIL rst_wrap_addr: got %h required fffffff8", wif.imem_addr); end
  endtask

  task automatic test_stream();
    int          first;
    logic [31:0] p, p4, a;
    logic [31:0] exp_a [3];
    exp_a[0] = 32'h0; exp_a[1] = 32'h4; exp_a[2] = 32'h8;
    do_reset(1, 1'b0);
    first = -1; p = '0; p4 = '0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (first < 0 && instr_valid) begin first = k; p = pc_out; p4 = pc4; end
      @(negedge clk);
    end
    n_cmp++; if (first !== 2) begin n_bad++; $display("FAIL stream_latency: got %0d cycles required 2", first); end
    n_cmp++; if (p !== 32'h0) begin n_bad++; $display("FAIL stream_first_pc: got %h required 0", p); end
    n_cmp++; if (p4 !== 32'h4) begin n_bad++; $display("FAIL stream_first_pc4: got %h required 4", p4); end
    for (int i = 0; i < 3; i++) begin
      a = (acc_log.size() > i) ? acc_log[i] : 32'hDEAD_BEEF;
      n_cmp++; if (a !== exp_a[i]) begin n_bad++; $display("FAIL stream_addr%0d: got %h required %h", i, a, exp_a[i]); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] hp, hi;
    @(negedge clk);
    stall = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    hp = pc_out; hi = instr_out;
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (mif.imem_req !== 1'b0) begin n_bad++; $display("FAIL stall_req c%0d: got %b required 0", c, mif.imem_req); end
      n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid c%0d: got %b required 1", c, instr_valid); end
      n_cmp++; if (pc_out !== hp || instr_out !== hi) begin
        n_bad++; $display("FAIL stall_hold c%0d: got pc=%h instr=%h required pc=%h instr=%h", c, pc_out, instr_out, hp, hi);
      end
      @(negedge clk); #1;
    end
    stall = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_gnt_low();
    int          w;
    logic [31:0] a;
    do_reset(1, 1'b0);
    w = 0;
    while (acc_log.size() < 2 && w < 10) begin @(negedge clk); w++; end
    mif.imem_gnt = 1'b0;
    #1;
    w = 0;
    while (!mif.imem_req && w < 10) begin @(negedge clk); #1; w++; end
    n_cmp++; if (mif.imem_req !== 1'b1) begin n_bad++; $display("FAIL gnt_wait: got req=%b required 1 within 10 cycles", mif.imem_req); end
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (mif.imem_req !== 1'b1) begin n_bad++; $display("FAIL gnt_hold_req c%0d: got %b required 1", c, mif.imem_req); end
      n_cmp++; if (mif.imem_addr !== 32'h8) begin n_bad++; $display("FAIL gnt_hold_addr c%0d: got %h required 8", c, mif.imem_addr); end
      @(negedge clk); #1;
    end
    mif.imem_gnt = 1'b1;
    #3;
    a = (acc_log.size() > 2) ? acc_log[2] : 32'hDEAD_BEEF;
    n_cmp++; if (a !== 32'h8) begin n_bad++; $display("FAIL gnt_accept: got %h required 8", a); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_redirect();
    int          w;
    logic [31:0] a;
    do_reset(3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (acc_log.size() !== 2) begin n_bad++; $display("FAIL redir_outstanding: got %0d required 2", acc_log.size()); end
    redirect = 1'b1; redirect_pc = 32'h103;
    #1;
    n_cmp++; if (mif.imem_req !== 1'b0) begin n_bad++; $display("FAIL redir_req: got %b required 0", mif.imem_req); end
    @(negedge clk);
    redirect = 1'b0;
    w = 0;
    while (acc_log.size() < 3 && w < 12) begin @(negedge clk); w++; end
    a = (acc_log.size() > 2) ? acc_log[2] : 32'hDEAD_BEEF;
    n_cmp++; if (a !== 32'h100) begin n_bad++; $display("FAIL redir_next_addr: got %h required 100", a); end
    #1;
    w = 0;
    while (!instr_valid && w < 12) begin @(negedge clk); #1; w++; end
    n_cmp++; if (instr_valid !== 1'b1 || pc_out !== 32'h100) begin
      n_bad++; $display("FAIL redir_first_pc: got valid=%b pc=%h required valid=1 pc=100", instr_valid, pc_out);
    end
    n_cmp++; if (instr_out !== mem_data(32'h100)) begin n_bad++; $display("FAIL redir_first_instr: got %h required %h", instr_out, mem_data(32'h100)); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_redirect_rvalid_stall();
    int w;
    do_reset(1, 1'b1);
    #1;
    w = 0;
    while (!(mif.imem_rvalid && instr_valid) && w < 12) begin @(negedge clk); #1; w++; end
    n_cmp++; if (!(mif.imem_rvalid && instr_valid)) begin n_bad++; $display("FAIL rvs_setup: got rvalid=%b valid=%b required both 1", mif.imem_rvalid, instr_valid); end
    redirect = 1'b1; redirect_pc = 32'h200;
    #1;
    n_cmp++; if (mif.imem_req !== 1'b0) begin n_bad++; $display("FAIL rvs_req: got %b required 0", mif.imem_req); end
    @(negedge clk);
    redirect = 1'b0;
    #1;
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rvs_empty: got valid=%b required 0", instr_valid); end
    n_cmp++; if (mif.imem_addr !== 32'h200) begin n_bad++; $display("FAIL rvs_addr: got %h required 200", mif.imem_addr); end
    stall = 1'b0;
    w = 0;
    while (!instr_valid && w < 12) begin @(negedge clk); #1; w++; end
    n_cmp++; if (instr_valid !== 1'b1 || pc_out !== 32'h200) begin
      n_bad++; $display("FAIL rvs_first_pc: got valid=%b pc=%h required valid=1 pc=200", instr_valid, pc_out);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_async_reset_wrap();
    logic        seen_fc;
    logic [31:0] a;
    logic [31:0] exp_a [3];
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0;
    do_reset(1, 1'b0);
    repeat (6) @(negedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (mif.imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_bad++; $display("FAIL arst_ctrl: got req=%b valid=%b required 0 0", mif.imem_req, instr_valid);
    end
    n_cmp++; if (instr_out !== 32'h0 || pc_out !== 32'h0 || pc4 !== 32'h0) begin
      n_bad++; $display("FAIL arst_data: got instr=%h pc=%h pc4=%h required 0 0 0", instr_out, pc_out, pc4);
    end
    n_cmp++; if (wif.imem_req !== 1'b0 || w_valid !== 1'b0 || w_pc4 !== 32'h0) begin
      n_bad++; $display("FAIL arst_wrap: got req=%b valid=%b pc4=%h required 0 0 0", wif.imem_req, w_valid, w_pc4);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_fc = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (w_valid && w_pc == 32'hFFFF_FFFC && !seen_fc) begin
        seen_fc = 1'b1;
        n_cmp++; if (w_pc4 !== 32'h0) begin n_bad++; $display("FAIL wrap_pc4: got %h required 0", w_pc4); end
      end
      @(negedge clk);
    end
    n_cmp++; if (seen_fc !== 1'b1) begin n_bad++; $display("FAIL wrap_seen: got %b required 1 (pc fffffffc never presented)", seen_fc); end
    for (int i = 0; i < 3; i++) begin
      a = (w_seen.size() > i) ? w_seen[i] : 32'hDEAD_BEEF;
      n_cmp++; if (a !== exp_a[i]) begin n_bad++; $display("FAIL wrap_addr%0d: got %h required %h", i, a, exp_a[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_gnt_low();
    test_redirect();
    test_redirect_rvalid_stall();
    test_async_reset_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
